arbiter_weighted: RTL and testbench
===================================

Name: arbiter_weighted

Overview:
- Parametrised successor to the bus arbiter: look-ahead round-robin with per-port runtime burst weights.
- An owner keeps the grant for up to weight[i] consecutive cycles while it keeps requesting. Ownership then passes to the next requester in circular order, with no idle cycle.
- Sits in front of shared buses and memory ports. Drop-in for existing request/grant users, plus an encoded grant index.

Parameters:
- NUM_PORTS, 6, number of requesters; must be >= 2.
- WEIGHT_WIDTH, 4, width of each per-port weight field; must be >= 1.
- ID_WIDTH (localparam), max(1, clog2(NUM_PORTS)), width of grant_id.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- request  in  [0:NUM_PORTS-1]  request bit per port; bit i is port i.
- weight  in  NUM_PORTS*WEIGHT_WIDTH  packed burst limits; port i is weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]. A value of 0 is treated as 1.
- grant  out  [0:NUM_PORTS-1]  registered, one-hot or zero.
- grant_id  out  ID_WIDTH  binary index of the current owner; valid only when active=1.
- active  out  1  registered; equals |grant.

Behaviour:
- Internal state:
  - owner: index of the last port granted.
  - count: number of grant cycles the owner has used in its current tenure.
- Reset (rst=0 at a clock edge), regardless of request:
  - grant=0, grant_id=0, active=0, count=0, owner=NUM_PORTS-1.
  - owner=NUM_PORTS-1 makes the first search start at port 0.
  - Reset mid-burst behaves the same way: the burst is abandoned, with no grant in the following cycle.
- Latency: exactly one cycle. Requests sampled at edge N drive grant after edge N.
- Weight: w(i) = max(1, weight field i). It is sampled every cycle, and changes take effect on the current comparison.
- Next-state rule, evaluated each edge with rst=1:
  1. HOLD: if active=1, request[owner]=1 and count+1 < w(owner):
     - keep owner; count <= count+1; grant stays asserted.
  2. PASS: otherwise, search ports owner+1, owner+2, ... wrapping modulo NUM_PORTS, ending at owner itself. Take the first i with request[i]=1:
     - owner <= i, count <= 0, grant <= onehot(i), grant_id <= i, active <= 1.
     - The current owner has lowest priority. It is re-granted, with count reset, only if no other port requests.
  3. IDLE: if no request bit is set:
     - grant <= 0, active <= 0, count <= 0; owner is retained, so fairness continues from there.
- Owner drop: the owner deasserting request mid-burst triggers PASS on that same edge. No dead cycle occurs when another port is requesting.
- Fairness bound: a requesting port waits at most the sum of w(j) over all other ports before it is granted.
- Width rules:
  - count is WEIGHT_WIDTH bits.
  - Compute count+1 at WEIGHT_WIDTH+1 bits so that a weight of all-ones never wraps.
  - Modulo indexing must be correct for non-power-of-two NUM_PORTS.
- Invariants:
  - grant is never multi-hot.
  - grant[i]=1 implies port i requested on the previous edge.
  - active == |grant.
  - When active=1, grant_id equals the index of the set grant bit.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst=0 for 3 cycles with request=all-ones, weights=1 -> grant=0, active=0 throughout. On the first edge after rst=1 -> grant[0]=1, grant_id=0, active=1.
- Plain round-robin: NUM_PORTS=6, all weights=1, request=all-ones continuously -> grant_id sequence 0,1,2,3,4,5,0,1 on consecutive cycles, active held at 1, no gaps.
- Weighted burst: w0=3, w1=2, others 1, only ports 0 and 1 requesting -> grant_id 0,0,0,1,1,0,0,0,1,1.
- Early release: w0=4, ports 0 and 2 requesting. Port 0 drops request after its 2nd grant cycle -> next cycle grant_id=2 with count restarted. Port 2 then holds for w2 cycles.
- Single requester and weight 0: only port 4 requesting, w4=0 -> port 4 granted every cycle, active continuously 1. Then drop all requests -> grant=0, active=0. Then raise ports 1 and 5 with owner=4 -> grant_id=5 first, then 1.
- Reset mid-burst: w3=8, port 3 granted for 2 cycles, assert rst=0 for one edge -> grant=0 in the next cycle. After release with only port 3 requesting -> port 3 re-granted with a full new burst of 8 cycles.

Source files
------------

// File: rtl/arbiter_weighted.sv
// Weighted look-ahead round-robin arbiter.
// The owner keeps the grant for up to w(owner) consecutive cycles while it
// keeps requesting. Ownership then passes to the next requester in circular
// order, with no idle cycle in between. All outputs come straight from flops.
module arbiter_weighted #(
  parameter  int NUM_PORTS    = 6,
  parameter  int WEIGHT_WIDTH = 4,
  localparam int ID_WIDTH     = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [0:NUM_PORTS-1]              request,
  input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight,
  output logic [0:NUM_PORTS-1]              grant,
  output logic [ID_WIDTH-1:0]               grant_id,
  output logic                              active
);

  // Port count at search-index width. The extra bit lets owner+k be formed
  // before it is folded back into range.
  localparam logic [ID_WIDTH:0] NP = (ID_WIDTH+1)'(NUM_PORTS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [ID_WIDTH-1:0]       owner_q, owner_d;
  logic [ID_WIDTH-1:0]       grant_id_q, grant_id_d;
  logic [WEIGHT_WIDTH-1:0]   count_q, count_d;
  logic [0:NUM_PORTS-1]      grant_q, grant_d;

  logic [WEIGHT_WIDTH-1:0]   w_eff [NUM_PORTS];
  logic [WEIGHT_WIDTH:0]     count_inc;
  logic [WEIGHT_WIDTH:0]     owner_limit;
  logic                      hold;
  logic                      any_req;
  logic [ID_WIDTH-1:0]       pick;
  logic [ID_WIDTH:0]         cand;

  // Unpack per-port burst limits; a programmed 0 behaves as 1.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_eff[i] = (weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0)
               ? WEIGHT_WIDTH'(1)
               : weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  // Burst check, one bit wider than count so an all-ones weight cannot wrap.
  always_comb begin
    count_inc   = {1'b0, count_q} + (WEIGHT_WIDTH+1)'(1);
    owner_limit = {1'b0, w_eff[owner_q]};
    hold        = (state_q == ST_OWN) && request[owner_q] &&
                  (count_inc < owner_limit);
  end

  // Circular search starting just after the owner and ending on the owner,
  // so the current owner has the lowest priority.
  always_comb begin
    any_req = 1'b0;
    pick    = owner_q;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = {1'b0, owner_q} + (ID_WIDTH+1)'(k);
      if (cand >= NP) begin
        cand = cand - NP;
      end
      if (!any_req && request[cand[ID_WIDTH-1:0]]) begin
        any_req = 1'b1;
        pick    = cand[ID_WIDTH-1:0];
      end
    end
  end

  // Next-state selection: HOLD the burst, PASS to the next requester, or IDLE.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    count_d    = count_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    if (hold) begin
      count_d = count_inc[WEIGHT_WIDTH-1:0];
    end else if (any_req) begin
      state_d       = ST_OWN;
      owner_d       = pick;
      count_d       = '0;
      grant_d       = '0;
      grant_d[pick] = 1'b1;
      grant_id_d    = pick;
    end else begin
      // Owner is kept so the next search resumes fairly from it.
      state_d = ST_IDLE;
      count_d = '0;
      grant_d = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= ID_WIDTH'(NUM_PORTS-1);
      count_q    <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      count_q    <= count_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign active   = (state_q == ST_OWN);

endmodule

// File: tb/tb_arbiter_weighted.sv
// Directed scoreboard bench for arbiter_weighted (6 ports, 4-bit weights).
module tb_arbiter_weighted;

  localparam int NP = 6;
  localparam int WW = 4;
  localparam int IW = 3;

  logic                 clk;
  logic                 rst;
  logic [0:NP-1]        request;
  logic [NP*WW-1:0]     weight;
  logic [0:NP-1]        grant;
  logic [IW-1:0]        grant_id;
  logic                 active;

  typedef struct {
    logic [0:NP-1] grant;
    logic [IW-1:0] id;
    logic          active;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  arbiter_weighted #(
    .NUM_PORTS   (NP),
    .WEIGHT_WIDTH(WW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .request (request),
    .weight  (weight),
    .grant   (grant),
    .grant_id(grant_id),
    .active  (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mask bit i -> port i.
  function automatic logic [0:NP-1] pm(input int unsigned mask);
    logic [0:NP-1] r;
    for (int i = 0; i < NP; i++) r[i] = mask[i];
    return r;
  endfunction

  function automatic logic [0:NP-1] onehot(input int unsigned id);
    logic [0:NP-1] r;
    r = '0;
    r[id] = 1'b1;
    return r;
  endfunction

  task automatic set_w(input int unsigned p, input int unsigned v);
    weight[p*WW +: WW] = WW'(v);
  endtask

  task automatic set_all_w(input int unsigned v);
    for (int unsigned p = 0; p < NP; p++) set_w(p, v);
  endtask

  // Drive inputs for one edge and queue the response expected after it.
  task automatic step(input logic rv, input int unsigned mask,
                      input logic ea, input int unsigned eid, input string tag);
    exp_t e;
    @(negedge clk);
    rst     = rv;
    request = pm(mask);
    e.active = ea;
    e.id     = IW'(eid);
    e.grant  = ea ? onehot(eid) : '0;
    e.tag    = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are presented every cycle; pop and compare after each edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (grant !== e.grant || active !== e.active ||
          (e.active && grant_id !== e.id)) begin
        n_bad++;
        $display("FAIL %s: got grant=%b id=%0d active=%b, want grant=%b id=%0d active=%b",
                 e.tag, grant, grant_id, active, e.grant, e.id, e.active);
      end
    end
  end

  initial begin : stim
    int unsigned seq_w[10];
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b0;
    request = '0;
    weight  = '0;
    set_all_w(1);

    // Reset held with all ports requesting, then plain round-robin.
    for (int i = 0; i < 3; i++) step(1'b0, 6'h3F, 1'b0, 0, "reset_hold");
    for (int i = 0; i < 8; i++) step(1'b1, 6'h3F, 1'b1, i % NP, "round_robin");

    // Weighted burst: w0=3, w1=2, ports 0 and 1.
    step(1'b0, 6'h03, 1'b0, 0, "wb_reset");
    set_w(0, 3); set_w(1, 2);
    seq_w = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    for (int i = 0; i < 10; i++) step(1'b1, 6'h03, 1'b1, seq_w[i], "weighted_burst");

    // Early release: w0=4, w2=3; port 0 drops after two grant cycles.
    step(1'b0, 6'h00, 1'b0, 0, "er_reset");
    set_all_w(1); set_w(0, 4); set_w(2, 3);
    step(1'b1, 6'h05, 1'b1, 0, "er_p0_first");
    step(1'b1, 6'h05, 1'b1, 0, "er_p0_hold");
    step(1'b1, 6'h04, 1'b1, 2, "er_pass_to_2");
    step(1'b1, 6'h04, 1'b1, 2, "er_p2_hold1");
    step(1'b1, 6'h04, 1'b1, 2, "er_p2_hold2");
    step(1'b1, 6'h05, 1'b1, 0, "er_p2_burst_end");

    // Single requester with weight 0, idle, then resume after owner 4.
    step(1'b0, 6'h00, 1'b0, 0, "sr_reset");
    set_all_w(1); set_w(4, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 6'h10, 1'b1, 4, "single_w0");
    step(1'b1, 6'h00, 1'b0, 0, "idle_1");
    step(1'b1, 6'h00, 1'b0, 0, "idle_2");
    step(1'b1, 6'h22, 1'b1, 5, "resume_5");
    step(1'b1, 6'h22, 1'b1, 1, "resume_1");
    step(1'b1, 6'h22, 1'b1, 5, "resume_5b");

    // Reset mid-burst: w3=8, then a full fresh burst before passing to port 2.
    step(1'b0, 6'h00, 1'b0, 0, "mb_reset");
    set_all_w(1); set_w(3, 8);
    step(1'b1, 6'h08, 1'b1, 3, "mb_p3_c0");
    step(1'b1, 6'h08, 1'b1, 3, "mb_p3_c1");
    step(1'b0, 6'h08, 1'b0, 0, "mb_abandon");
    step(1'b1, 6'h08, 1'b1, 3, "mb_regrant");
    for (int i = 0; i < 7; i++) step(1'b1, 6'h0C, 1'b1, 3, "mb_full_burst");
    step(1'b1, 6'h0C, 1'b1, 2, "mb_pass_to_2");

    // Maximum weight: w1=15 holds 15 cycles without wrapping.
    step(1'b0, 6'h00, 1'b0, 0, "mx_reset");
    set_all_w(1); set_w(1, 15);
    step(1'b1, 6'h03, 1'b1, 0, "mx_p0");
    for (int i = 0; i < 15; i++) step(1'b1, 6'h03, 1'b1, 1, "mx_p1_burst");
    step(1'b1, 6'h03, 1'b1, 0, "mx_back_to_0");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
